// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU arbiter slice.
//   OP_*  : 2-bit opcodes understood by alu_core
//   ST_*  : 2-bit sequencer state encodings used by alu_arbiter
package alu_pkg;

    localparam int unsigned OP_W = 2;
    localparam int unsigned ST_W = 2;

    localparam logic [OP_W-1:0] OP_AND = 2'b00;
    localparam logic [OP_W-1:0] OP_OR  = 2'b01;
    localparam logic [OP_W-1:0] OP_XOR = 2'b10;
    localparam logic [OP_W-1:0] OP_ADD = 2'b11;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_EXEC = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational shared ALU datapath.
//   op   in  2     opcode (AND/OR/XOR/ADD)
//   a, b in  size  operands
//   y    out size  result (ADD wraps modulo 2^size)
//   cout out 1     carry-out of ADD, 0 for logic ops
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned size = 8
) (
    input  logic [OP_W-1:0] op,
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    output logic [size-1:0] y,
    output logic            cout
);

    logic [size-1:0] w_and;
    logic [size-1:0] w_or;
    logic [size-1:0] w_xor;
    logic [size:0]   w_sum;

    // Per-bit gate operators.
    for (genvar i = 0; i < int'(size); i++) begin : g_bit
        assign w_and[i] = a[i] & b[i];
        assign w_or[i]  = a[i] | b[i];
        assign w_xor[i] = a[i] ^ b[i];
    end

    // One bit wider than the operands so the carry falls out of the sum.
    assign w_sum = {1'b0, a} + {1'b0, b};

    // Result / carry select.
    always_comb begin
        y    = w_and;
        cout = 1'b0;
        case (op)
            OP_AND:  y = w_and;
            OP_OR:   y = w_or;
            OP_XOR:  y = w_xor;
            OP_ADD: begin
                y    = w_sum[size-1:0];
                cout = w_sum[size];
            end
            default: y = w_and;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer sharing one alu_core between two requesters.
//   clk, rst              clock, async active-high reset
//   req0/1, op0/1         request + opcode per requester (held until ackn)
//   a0/b0, a1/b1          operands per requester
//   ack0/1                one-cycle pulse: operands captured
//   result/carry/zero     registered ALU outputs
//   res_id                requester owning the result
//   res_valid/res_ready   result handshake
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned size = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic            req1,
    input  logic [1:0]      op0,
    input  logic [1:0]      op1,
    input  logic [size-1:0] a0,
    input  logic [size-1:0] b0,
    input  logic [size-1:0] a1,
    input  logic [size-1:0] b1,
    output logic            ack0,
    output logic            ack1,
    output logic [size-1:0] result,
    output logic            carry,
    output logic            zero,
    output logic            res_id,
    output logic            res_valid,
    input  logic            res_ready
);

    logic [ST_W-1:0] r_state;
    logic [ST_W-1:0] w_state_nxt;
    logic            r_last_id;
    logic [OP_W-1:0] r_op;
    logic [size-1:0] r_a;
    logic [size-1:0] r_b;
    logic            r_id;

    logic            w_grant;
    logic            w_grant_id;
    logic            w_load;
    logic            w_release;
    logic [size-1:0] w_y;
    logic            w_cout;

    alu_core #(.size(size)) u_alu_core (
        .op   (r_op),
        .a    (r_a),
        .b    (r_b),
        .y    (w_y),
        .cout (w_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (req0 || req1) w_state_nxt = ST_EXEC;
            ST_EXEC: w_state_nxt = ST_DONE;
            ST_DONE: if (res_valid && res_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Control strobes; on a tie the requester not served last wins.
    always_comb begin
        w_grant    = 1'b0;
        w_grant_id = 1'b0;
        w_load     = 1'b0;
        w_release  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    w_grant    = 1'b1;
                    w_grant_id = (req0 && req1) ? ~r_last_id : req1;
                end
            end
            ST_EXEC: w_load    = 1'b1;
            ST_DONE: w_release = res_valid && res_ready;
            default: ;
        endcase
    end

    // Operand capture, ack pulses and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_id <= 1'b1;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_id      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            res_id    <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            if (w_grant) begin
                r_op      <= w_grant_id ? op1 : op0;
                r_a       <= w_grant_id ? a1  : a0;
                r_b       <= w_grant_id ? b1  : b0;
                r_id      <= w_grant_id;
                r_last_id <= w_grant_id;
                ack0      <= ~w_grant_id;
                ack1      <= w_grant_id;
            end
            if (w_load) begin
                result    <= w_y;
                carry     <= w_cout;
                zero      <= (w_y == '0);
                res_id    <= r_id;
                res_valid <= 1'b1;
            end
            if (w_release) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed + randomized bench for alu_arbiter against a
// transaction-level reference model (per-requester op queues, round-robin
// pointer, arithmetic result function, age-since-grant timing).
module tb_alu_arbiter;

    localparam int unsigned SIZE = 8;

    typedef struct {
        logic [1:0]      op;
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
    } op_t;

    logic            clk;
    logic            rst;
    logic            req0, req1;
    logic [1:0]      op0, op1;
    logic [SIZE-1:0] a0, b0, a1, b1;
    logic            ack0, ack1;
    logic [SIZE-1:0] result;
    logic            carry, zero, res_id, res_valid;
    logic            res_ready;

    int n_checks = 0;
    int n_errors = 0;

    op_t q0[$];
    op_t q1[$];
    logic [SIZE+2:0] done_log[$];   // {id, zero, carry, result} per completed handshake

    // Reference model state
    bit              m_busy;
    int              m_age;
    bit              m_id;
    bit              m_last;
    logic [SIZE:0]   m_exp;

    alu_arbiter #(.size(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .op0       (op0),
        .op1       (op1),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .ack0      (ack0),
        .ack1      (ack1),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .res_id    (res_id),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {carry, result} from plain arithmetic.
    function automatic logic [SIZE:0] ref_alu(input logic [1:0] op, input logic [SIZE-1:0] a,
                                             input logic [SIZE-1:0] b);
        case (op)
            2'd0:    ref_alu = {1'b0, a & b};
            2'd1:    ref_alu = {1'b0, a | b};
            2'd2:    ref_alu = {1'b0, a ^ b};
            default: ref_alu = (SIZE+1)'(a) + (SIZE+1)'(b);
        endcase
    endfunction

    task automatic drive_inputs();
        req0 = (q0.size() > 0);
        req1 = (q1.size() > 0);
        if (q0.size() > 0) begin
            op0 = q0[0].op; a0 = q0[0].a; b0 = q0[0].b;
        end
        if (q1.size() > 0) begin
            op1 = q1[0].op; a1 = q1[0].a; b1 = q1[0].b;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ack0"},      32'(ack0),      32'd0);
        check({tag, "_ack1"},      32'(ack1),      32'd0);
        check({tag, "_result"},    32'(result),    32'd0);
        check({tag, "_carry"},     32'(carry),     32'd0);
        check({tag, "_zero"},      32'(zero),      32'd0);
        check({tag, "_res_id"},    32'(res_id),    32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    endtask

    // One clock: predict from the driven inputs, take the edge, compare.
    task automatic step();
        bit g, gid, hs;
        drive_inputs();
        if (res_valid && res_ready)
            done_log.push_back({res_id, zero, carry, result});
        g   = !m_busy && (req0 || req1);
        gid = (req0 && req1) ? !m_last : req1;
        hs  = m_busy && (m_age >= 1) && res_ready;
        @(posedge clk);
        #1;
        if (hs) m_busy = 1'b0;
        else if (m_busy) m_age++;
        if (g) begin
            m_busy = 1'b1;
            m_age  = 0;
            m_id   = gid;
            m_last = gid;
            if (gid) begin
                m_exp = ref_alu(q1[0].op, q1[0].a, q1[0].b);
                void'(q1.pop_front());
            end else begin
                m_exp = ref_alu(q0[0].op, q0[0].a, q0[0].b);
                void'(q0.pop_front());
            end
        end
        check("ack0", 32'(ack0), 32'(m_busy && m_age == 0 && !m_id));
        check("ack1", 32'(ack1), 32'(m_busy && m_age == 0 && m_id));
        check("res_valid", 32'(res_valid), 32'(m_busy && m_age >= 1));
        if (m_busy && m_age >= 1) begin
            check("result", 32'(result), 32'(m_exp[SIZE-1:0]));
            check("carry",  32'(carry),  32'(m_exp[SIZE]));
            check("zero",   32'(zero),   32'(m_exp[SIZE-1:0] == '0));
            check("res_id", 32'(res_id), 32'(m_id));
        end
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_busy) && n < max_cycles) begin
            step();
            n++;
        end
        if (q0.size() > 0 || q1.size() > 0 || m_busy)
            check("drain_timeout", 32'd1, 32'd0);
        step();  // log the final handshake and confirm the bus is quiet
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic apply_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check_zero_outputs(tag);
        m_busy = 1'b0;
        m_last = 1'b1;
        q0.delete();
        q1.delete();
        drive_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic op_t mk(input logic [1:0] op, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        op_t t;
        t.op = op; t.a = a; t.b = b;
        return t;
    endfunction

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        res_ready = 1'b1;
        m_busy = 1'b0; m_age = 0; m_id = 1'b0; m_last = 1'b1; m_exp = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        repeat (3) step();

        // Single AND op
        done_log.delete();
        q0.push_back(mk(2'b00, 8'hF0, 8'h3C));
        drain(20);
        check("single_count", 32'(done_log.size()), 32'd1);
        if (done_log.size() >= 1)
            check("single_res", 32'(done_log[0]), 32'({1'b0, 1'b0, 1'b0, 8'h30}));

        // Mid-cycle async reset clears a held nonzero result
        apply_reset("async_rst");
        repeat (2) step();

        // Tie, then a second tie to show alternation
        done_log.delete();
        q0.push_back(mk(2'b10, 8'hAA, 8'h55));
        q1.push_back(mk(2'b01, 8'h0F, 8'hF0));
        drain(30);
        q0.push_back(mk(2'b00, 8'h0F, 8'h0F));
        q1.push_back(mk(2'b00, 8'hF0, 8'hF0));
        drain(30);
        check("tie_count", 32'(done_log.size()), 32'd4);
        if (done_log.size() >= 4) begin
            check("tie1_first",  32'(done_log[0]), 32'({1'b0, 1'b0, 1'b0, 8'hFF}));
            check("tie1_second", 32'(done_log[1]), 32'({1'b1, 1'b0, 1'b0, 8'hFF}));
            check("tie2_first",  32'(done_log[2]), 32'({1'b0, 1'b0, 1'b0, 8'h0F}));
            check("tie2_second", 32'(done_log[3]), 32'({1'b1, 1'b0, 1'b0, 8'hF0}));
        end

        // Backpressure: result held, pending req1 not acked
        done_log.delete();
        res_ready = 1'b0;
        q0.push_back(mk(2'b11, 8'h12, 8'h34));
        step();
        step();
        q1.push_back(mk(2'b10, 8'h3C, 8'h3C));
        repeat (5) step();
        check("bp_req1_pending", 32'(q1.size()), 32'd1);
        res_ready = 1'b1;
        drain(20);
        check("bp_count", 32'(done_log.size()), 32'd2);
        if (done_log.size() >= 2) begin
            check("bp_first",  32'(done_log[0]), 32'({1'b0, 1'b0, 1'b0, 8'h46}));
            check("bp_second", 32'(done_log[1]), 32'({1'b1, 1'b1, 1'b0, 8'h00}));
        end

        // ADD wrap and non-wrap
        done_log.delete();
        q0.push_back(mk(2'b11, 8'hFF, 8'h01));
        drain(20);
        q0.push_back(mk(2'b11, 8'h7F, 8'h01));
        drain(20);
        check("add_count", 32'(done_log.size()), 32'd2);
        if (done_log.size() >= 2) begin
            check("add_wrap",   32'(done_log[0]), 32'({1'b0, 1'b1, 1'b1, 8'h00}));
            check("add_nowrap", 32'(done_log[1]), 32'({1'b0, 1'b0, 1'b0, 8'h80}));
        end

        // Reset during EXEC drops the op; next req1 completes normally
        done_log.delete();
        q1.push_back(mk(2'b01, 8'h01, 8'h02));
        step();
        apply_reset("rst_exec");
        repeat (3) step();
        q1.push_back(mk(2'b11, 8'h80, 8'h81));
        drain(20);
        check("rst_exec_count", 32'(done_log.size()), 32'd1);
        if (done_log.size() >= 1)
            check("rst_exec_res", 32'(done_log[0]), 32'({1'b1, 1'b0, 1'b1, 8'h01}));

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            if (q0.size() < 2 && $urandom_range(0, 2) == 0)
                q0.push_back(mk(2'($urandom_range(0, 3)), SIZE'($urandom), SIZE'($urandom)));
            if (q1.size() < 2 && $urandom_range(0, 2) == 0)
                q1.push_back(mk(2'($urandom_range(0, 3)), SIZE'($urandom), SIZE'($urandom)));
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        res_ready = 1'b1;
        drain(100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
